noise_downsample: RTL and testbench
===================================

Name: noise_downsample

Overview:
- Integrate-and-dump decimator directly upstream of the tracking-engine noise floor calculator.
- Accumulates N complex input samples per output and rounds/scales the sum.
- Saturates each output to a symmetric DATA_BITS range.
- Emits data_down_en / i_data_down / q_data_down, plus a shift_code strobe that advances the noise PRN once per chip group.
- Also counts saturation events so firmware can tune the scaling.

Parameters:
- IN_BITS, 8, width of signed input I/Q samples
- DATA_BITS, 6, width of signed decimated output samples
- CNT_WIDTH, 8, width of decimation counter and down_factor

Ports:
- clk  input  1  system clock
- rst_b  input  1  asynchronous reset, active low
- enable  input  1  block enable; low = idle and flush
- sample_valid  input  1  input sample strobe
- i_data_in  input  IN_BITS  signed in-phase sample
- q_data_in  input  IN_BITS  signed quadrature sample
- down_factor  input  CNT_WIDTH  samples per output minus 1 (N = down_factor+1)
- shift_bits  input  4  right-shift applied to accumulated sum
- chip_ratio  input  4  outputs per code chip minus 1
- clear_sat  input  1  synchronous clear of sat_count
- data_down_en  output  1  decimated-sample valid pulse
- i_data_down  output  DATA_BITS  signed decimated I
- q_data_down  output  DATA_BITS  signed decimated Q
- shift_code  output  1  code-advance strobe, coincident with a data_down_en
- sat_count  output  16  saturated-output counter

Behaviour:
- Reset: all outputs 0; accumulators, sample counter and chip counter 0; state IDLE.
- Accumulator width: ACC_W = IN_BITS+CNT_WIDTH. Inputs are sign-extended, so no internal overflow is possible.
- IDLE (enable=0):
  - Accumulators and counters are held at 0.
  - data_down_en=0, shift_code=0; output data registers keep their last value.
  - enable rising -> ACC on the next clock. down_factor and chip_ratio are latched into period registers on that edge.
- ACC:
  - On each sample_valid, acc += input and sample count increments.
  - When sample_valid arrives with count == latched down_factor, the dump path runs:
    - sum = acc + current input.
    - Round: if shift_bits>0, add 2^(shift_bits-1); then arithmetic right shift by shift_bits. shift_bits is sampled at dump time.
    - Saturate to [-(2^(DATA_BITS-1)-1), +(2^(DATA_BITS-1)-1)] (±31 for 6 bits). The most-negative code is never produced, so downstream negation is safe.
    - Next cycle: data_down_en=1 for exactly one cycle, with i/q_data_down registered.
    - Same edge: acc reloads 0, count reloads 0, down_factor is re-latched.
  - Latency: one clock from the last contributing sample_valid to data_down_en.
  - With down_factor=0, every valid sample dumps. Back-to-back valids give data_down_en high on consecutive cycles.
- Chip counter:
  - Increments on each dump.
  - On the dump where chip counter == latched chip_ratio, shift_code=1 in the same cycle as data_down_en; the counter resets to 0 and chip_ratio is re-latched.
  - chip_ratio=0 gives shift_code on every output.
- enable falling mid-period:
  - The partial sum is discarded and counters clear; no output is produced.
  - A dump already registered still appears on the following cycle.
- sample_valid while enable=0: ignored.
- sat_count:
  - +1 per dump in which I or Q (either or both) saturated; saturates at 0xFFFF.
  - clear_sat has priority over an increment in the same cycle; it counts regardless of enable.
- Reset asserted mid-operation: immediate return to reset values; no partial output.

Test Plan:
- Reset: assert rst_b=0 during activity -> all outputs 0 immediately; after release, no data_down_en until enable is asserted and N valids are applied.
- Basic decimation: DATA_BITS=6, down_factor=3, shift_bits=2, chip_ratio=0, inputs I=+5,+6,+7,+8 and Q=-1 x4 -> one cycle after the 4th valid, data_down_en=1 and shift_code=1 with i_data_down=7 ((26+2)>>2) and q_data_down=-1 ((-4+2)>>2); no other pulses.
- Saturation: down_factor=7, shift_bits=0, I=+100 x8 and Q=-100 x8 -> i_data_down=+31, q_data_down=-31 (not -32), sat_count=1; then assert clear_sat in the same cycle as the next saturating dump -> sat_count=0.
- Chip grouping: down_factor=0, chip_ratio=2, continuous valids -> data_down_en every cycle, shift_code on every third output; change chip_ratio to 0 mid-group -> new value takes effect only after the current group completes.
- Enable drop: down_factor=9, deassert enable after 5 valids, re-enable, then apply 10 valids -> exactly one output, equal to the sum of only the last 10 samples.
- down_factor update: change down_factor from 3 to 1 two samples into a period -> current period still takes 4 samples; the following periods take 2.

Source files
------------

// File: rtl/noise_downsample.sv
// Integrate-and-dump I/Q decimator: sums N samples, rounds, shifts and saturates to +/-(2^(DATA_BITS-1)-1).
// Output one clock after the last contributing sample; no backpressure, sample_valid is a strobe.
module noise_downsample #(
    parameter int IN_BITS   = 8,
    parameter int DATA_BITS = 6,
    parameter int CNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        enable,
    input  logic                        sample_valid,
    input  logic signed [IN_BITS-1:0]   i_data_in,
    input  logic signed [IN_BITS-1:0]   q_data_in,
    input  logic        [CNT_WIDTH-1:0] down_factor,
    input  logic        [3:0]           shift_bits,
    input  logic        [3:0]           chip_ratio,
    input  logic                        clear_sat,
    output logic                        data_down_en,
    output logic signed [DATA_BITS-1:0] i_data_down,
    output logic signed [DATA_BITS-1:0] q_data_down,
    output logic                        shift_code,
    output logic        [15:0]          sat_count
);

    localparam int ACC_W = IN_BITS + CNT_WIDTH;
    // One extra bit so the rounding offset cannot wrap a full-scale sum.
    localparam int RND_W = ACC_W + 1;
    localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((1 << (DATA_BITS - 1)) - 1);
    localparam logic signed [RND_W-1:0] SAT_MIN = -SAT_MAX;

    typedef enum logic {S_IDLE, S_ACC} state_t;

    state_t                      state_q, state_d;
    logic signed [ACC_W-1:0]     acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0]     acc_q_q, acc_q_d;
    logic        [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic        [CNT_WIDTH-1:0] period_q, period_d;
    logic        [3:0]           chip_cnt_q, chip_cnt_d;
    logic        [3:0]           chip_period_q, chip_period_d;
    logic                        den_q, den_d;
    logic                        sc_q, sc_d;
    logic signed [DATA_BITS-1:0] i_out_q, i_out_d;
    logic signed [DATA_BITS-1:0] q_out_q, q_out_d;
    logic        [15:0]          sat_cnt_q, sat_cnt_d;

    logic signed [ACC_W-1:0]     sum_i;
    logic signed [ACC_W-1:0]     sum_q;
    logic signed [DATA_BITS-1:0] i_scaled;
    logic signed [DATA_BITS-1:0] q_scaled;
    logic                        i_sat;
    logic                        q_sat;
    logic                        dump;

    function automatic logic signed [DATA_BITS-1:0] scale_sat(
        input  logic signed [ACC_W-1:0] sum,
        input  logic        [3:0]       sh,
        output logic                    sat
    );
        logic signed [RND_W-1:0] ext;
        logic signed [RND_W-1:0] res;
        ext = {sum[ACC_W-1], sum};
        if (sh != 4'd0) begin
            ext = ext + (RND_W'(1) << (sh - 4'd1));
        end
        res = ext >>> sh;
        sat = 1'b1;
        if (res > SAT_MAX) begin
            scale_sat = SAT_MAX[DATA_BITS-1:0];
        end else if (res < SAT_MIN) begin
            scale_sat = SAT_MIN[DATA_BITS-1:0];
        end else begin
            scale_sat = res[DATA_BITS-1:0];
            sat       = 1'b0;
        end
    endfunction

    assign sum_i = acc_i_q + {{CNT_WIDTH{i_data_in[IN_BITS-1]}}, i_data_in};
    assign sum_q = acc_q_q + {{CNT_WIDTH{q_data_in[IN_BITS-1]}}, q_data_in};

    always_comb begin
        i_scaled = scale_sat(sum_i, shift_bits, i_sat);
        q_scaled = scale_sat(sum_q, shift_bits, q_sat);
    end

    always_comb begin
        state_d       = state_q;
        acc_i_d       = acc_i_q;
        acc_q_d       = acc_q_q;
        cnt_d         = cnt_q;
        period_d      = period_q;
        chip_cnt_d    = chip_cnt_q;
        chip_period_d = chip_period_q;
        den_d         = 1'b0;
        sc_d          = 1'b0;
        i_out_d       = i_out_q;
        q_out_d       = q_out_q;
        sat_cnt_d     = sat_cnt_q;
        dump          = 1'b0;

        case (state_q)
            S_IDLE: begin
                acc_i_d    = '0;
                acc_q_d    = '0;
                cnt_d      = '0;
                chip_cnt_d = '0;
                if (enable) begin
                    state_d       = S_ACC;
                    period_d      = down_factor;
                    chip_period_d = chip_ratio;
                end
            end
            S_ACC: begin
                if (!enable) begin
                    // Partial period is discarded, nothing is emitted.
                    state_d    = S_IDLE;
                    acc_i_d    = '0;
                    acc_q_d    = '0;
                    cnt_d      = '0;
                    chip_cnt_d = '0;
                end else if (sample_valid) begin
                    if (cnt_q == period_q) begin
                        dump     = 1'b1;
                        den_d    = 1'b1;
                        i_out_d  = i_scaled;
                        q_out_d  = q_scaled;
                        acc_i_d  = '0;
                        acc_q_d  = '0;
                        cnt_d    = '0;
                        period_d = down_factor;
                        if (chip_cnt_q == chip_period_q) begin
                            sc_d          = 1'b1;
                            chip_cnt_d    = '0;
                            chip_period_d = chip_ratio;
                        end else begin
                            chip_cnt_d = chip_cnt_q + 4'd1;
                        end
                    end else begin
                        acc_i_d = sum_i;
                        acc_q_d = sum_q;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clear_sat) begin
            sat_cnt_d = '0;
        end else if (dump && (i_sat || q_sat) && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= S_IDLE;
            acc_i_q       <= '0;
            acc_q_q       <= '0;
            cnt_q         <= '0;
            period_q      <= '0;
            chip_cnt_q    <= '0;
            chip_period_q <= '0;
            den_q         <= 1'b0;
            sc_q          <= 1'b0;
            i_out_q       <= '0;
            q_out_q       <= '0;
            sat_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            acc_i_q       <= acc_i_d;
            acc_q_q       <= acc_q_d;
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            chip_cnt_q    <= chip_cnt_d;
            chip_period_q <= chip_period_d;
            den_q         <= den_d;
            sc_q          <= sc_d;
            i_out_q       <= i_out_d;
            q_out_q       <= q_out_d;
            sat_cnt_q     <= sat_cnt_d;
        end
    end

    assign data_down_en = den_q;
    assign shift_code   = sc_q;
    assign i_data_down  = i_out_q;
    assign q_data_down  = q_out_q;
    assign sat_count    = sat_cnt_q;

endmodule

// File: tb/tb_noise_downsample.sv
// Bench for noise_downsample: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_noise_downsample;

    logic              clk = 1'b0;
    logic              rst_b = 1'b0;
    logic              enable = 1'b0;
    logic              sample_valid = 1'b0;
    logic signed [7:0] i_data_in = '0;
    logic signed [7:0] q_data_in = '0;
    logic        [7:0] down_factor = '0;
    logic        [3:0] shift_bits = '0;
    logic        [3:0] chip_ratio = '0;
    logic              clear_sat = 1'b0;
    logic              data_down_en;
    logic signed [5:0] i_data_down;
    logic signed [5:0] q_data_down;
    logic              shift_code;
    logic       [15:0] sat_count;

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    int n_sc  = 0;

    always #5 clk = ~clk;

    noise_downsample dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .enable       (enable),
        .sample_valid (sample_valid),
        .i_data_in    (i_data_in),
        .q_data_in    (q_data_in),
        .down_factor  (down_factor),
        .shift_bits   (shift_bits),
        .chip_ratio   (chip_ratio),
        .clear_sat    (clear_sat),
        .data_down_en (data_down_en),
        .i_data_down  (i_data_down),
        .q_data_down  (q_data_down),
        .shift_code   (shift_code),
        .sat_count    (sat_count)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: collect the samples of a period, sum them at the end.
    bit m_act = 0;
    int m_si[$];
    int m_sq[$];
    int m_per = 0, m_cper = 0, m_chip = 0;
    int m_i = 0, m_q = 0, m_sat = 0;
    bit m_en = 0, m_sc = 0;

    function automatic int rnd_sat(input int s, input int sh, output bit st);
        int r;
        r = s;
        if (sh > 0) r += (1 << (sh - 1));
        r = r >>> sh;
        st = 1'b0;
        if (r > 31) begin r = 31; st = 1'b1; end
        else if (r < -31) begin r = -31; st = 1'b1; end
        return r;
    endfunction

    always @(posedge clk or negedge rst_b) begin
        bit dump, si, sq;
        int ti, tq;
        if (!rst_b) begin
            m_act = 0; m_si.delete(); m_sq.delete();
            m_per = 0; m_cper = 0; m_chip = 0;
            m_i = 0; m_q = 0; m_sat = 0; m_en = 0; m_sc = 0;
        end else begin
            dump = 0; si = 0; sq = 0;
            m_en = 0; m_sc = 0;
            if (!enable) begin
                m_act = 0; m_si.delete(); m_sq.delete(); m_chip = 0;
            end else if (!m_act) begin
                m_act = 1; m_per = int'(down_factor); m_cper = int'(chip_ratio);
            end else if (sample_valid) begin
                m_si.push_back(int'(i_data_in));
                m_sq.push_back(int'(q_data_in));
                if (m_si.size() == m_per + 1) begin
                    ti = 0; tq = 0;
                    foreach (m_si[k]) begin ti += m_si[k]; tq += m_sq[k]; end
                    m_i = rnd_sat(ti, int'(shift_bits), si);
                    m_q = rnd_sat(tq, int'(shift_bits), sq);
                    m_en = 1; dump = 1;
                    if (m_chip == m_cper) begin
                        m_sc = 1; m_chip = 0; m_cper = int'(chip_ratio);
                    end else begin
                        m_chip++;
                    end
                    m_per = int'(down_factor);
                    m_si.delete(); m_sq.delete();
                end
            end
            if (clear_sat) m_sat = 0;
            else if (dump && (si || sq) && m_sat < 65535) m_sat++;
        end
    end

    always @(negedge clk) begin
        if (rst_b) begin
            chk("en", data_down_en, m_en);
            chk("sc", shift_code, m_sc);
            chk("i", i_data_down, m_i);
            chk("q", q_data_down, m_q);
            chk("sat", sat_count, m_sat);
            if (data_down_en) n_out++;
            if (shift_code) n_sc++;
        end
    end

    task automatic step(input bit v, input int iv, input int qv);
        @(negedge clk); #1;
        sample_valid = v;
        i_data_in    = 8'(iv);
        q_data_in    = 8'(qv);
    endtask

    task automatic restart(input int df, input int cr, input int sh);
        @(negedge clk); #1;
        enable = 1'b0; sample_valid = 1'b0;
        down_factor = 8'(df); chip_ratio = 4'(cr); shift_bits = 4'(sh);
        @(negedge clk); #1;
        enable = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en"}, data_down_en, 0);
        chk({tag, "_sc"}, shift_code, 0);
        chk({tag, "_i"}, i_data_down, 0);
        chk({tag, "_q"}, q_data_down, 0);
        chk({tag, "_sat"}, sat_count, 0);
    endtask

    initial begin
        int o, o_sc;
        @(negedge clk); #1;
        chk_reset_outputs("rst0");
        rst_b = 1'b1;

        // Valids while disabled are ignored.
        o = n_out;
        repeat (4) step(1, 50, 50);
        step(0, 0, 0);
        chk("idle_no_out", n_out - o, 0);

        // Basic decimation with rounding.
        restart(3, 0, 2);
        o = n_out;
        step(1, 5, -1); step(1, 6, -1); step(1, 7, -1); step(1, 8, -1);
        step(0, 0, 0);
        chk("basic_en", data_down_en, 1);
        chk("basic_sc", shift_code, 1);
        chk("basic_i", i_data_down, 7);
        chk("basic_q", q_data_down, -1);
        repeat (3) step(0, 0, 0);
        chk("basic_cnt", n_out - o, 1);

        // Symmetric saturation and clear_sat priority.
        restart(7, 0, 0);
        repeat (8) step(1, 100, -100);
        step(0, 0, 0);
        chk("satur_i", i_data_down, 31);
        chk("satur_q", q_data_down, -31);
        chk("satur_cnt", sat_count, 1);
        repeat (8) step(1, 100, -100);
        clear_sat = 1'b1;
        step(0, 0, 0);
        clear_sat = 1'b0;
        chk("clr_en", data_down_en, 1);
        chk("clr_cnt", sat_count, 0);

        // Chip grouping with a mid-group chip_ratio change.
        restart(0, 2, 0);
        o = n_out; o_sc = n_sc;
        for (int k = 1; k <= 12; k++) begin
            step(1, k, -k);
            if (k == 4) chip_ratio = 4'd0;
        end
        step(0, 0, 0);
        chk("chip_out", n_out - o, 12);
        chk("chip_sc", n_sc - o_sc, 8);

        // Enable drop discards the partial sum.
        restart(9, 0, 0);
        o = n_out;
        repeat (5) step(1, 7, 7);
        @(negedge clk); #1; enable = 1'b0; sample_valid = 1'b0;
        @(negedge clk); #1; enable = 1'b1;
        repeat (10) step(1, 3, -2);
        step(0, 0, 0);
        chk("edrop_cnt", n_out - o, 1);
        chk("edrop_i", i_data_down, 30);
        chk("edrop_q", q_data_down, -20);

        // down_factor change takes effect after the current period.
        restart(3, 0, 0);
        o = n_out;
        step(1, 1, 1); step(1, 1, 1);
        down_factor = 8'd1;
        step(1, 1, 1); step(1, 1, 1);
        chk("df_cnt3", n_out - o, 0);
        step(1, 2, 2);
        chk("df_cnt4", n_out - o, 1);
        chk("df_i4", i_data_down, 4);
        step(1, 2, 2);
        chk("df_cnt5", n_out - o, 1);
        step(1, 3, 3);
        chk("df_cnt6", n_out - o, 2);
        step(1, 3, 3);
        step(0, 0, 0);
        chk("df_cnt8", n_out - o, 3);
        chk("df_i8", i_data_down, 6);

        // Full-scale accumulation with maximum shift.
        restart(255, 0, 15);
        repeat (256) step(1, 127, -128);
        step(0, 0, 0);
        chk("big_i", i_data_down, 1);
        chk("big_q", q_data_down, -1);

        // Randomized traffic with an asynchronous reset in the middle.
        restart(2, 1, 2);
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) begin
                @(negedge clk); #1;
                rst_b = 1'b0;
                #1;
                chk_reset_outputs("rst_mid");
                @(negedge clk); #1;
                rst_b = 1'b1;
            end
            @(negedge clk); #1;
            sample_valid = ($urandom % 10) < 7;
            i_data_in    = 8'($urandom_range(0, 255));
            q_data_in    = 8'($urandom_range(0, 255));
            enable       = ($urandom % 50) != 0;
            clear_sat    = ($urandom % 20) == 0;
            shift_bits   = 4'($urandom_range(0, 5));
            if (($urandom % 20) == 0) down_factor = 8'($urandom_range(0, 5));
            if (($urandom % 20) == 0) chip_ratio  = 4'($urandom_range(0, 3));
        end
        step(0, 0, 0);
        clear_sat = 1'b0;
        repeat (3) step(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
